// File: rtl/seq_divider.sv
// Multi-cycle signed divider: restoring shift-subtract on magnitudes,
// one quotient bit per clock, sign fix-up in a final cycle.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             DivZero,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;

    logic [WIDTH-1:0] rem_sh;
    logic             ge;
    logic [CW-1:0]    cnt_dec;

    // Dividend register doubles as the quotient: bits shift out the top
    // while quotient bits shift in at the bottom.
    assign rem_sh  = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    assign ge      = {1'b0, rem_sh} >= {1'b0, bmag_q};
    assign cnt_dec = cnt_q - CW'(1);

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ovf_d   = ovf_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ov_d    = ov_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && B == '0) begin
                    q_d    = '0;
                    r_d    = A;
                    dz_d   = 1'b1;
                    ov_d   = 1'b0;
                    done_d = 1'b1;
                end else if (start) begin
                    sa_d    = A[WIDTH-1];
                    sb_d    = B[WIDTH-1];
                    dvd_d   = A[WIDTH-1] ? WIDTH'(-A) : A;
                    bmag_d  = B[WIDTH-1] ? WIDTH'(-B) : B;
                    ovf_d   = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = ge ? WIDTH'(rem_sh - bmag_q) : rem_sh;
                dvd_d = {dvd_q[WIDTH-2:0], ge};
                cnt_d = cnt_dec;
                if (cnt_dec == '0) state_d = S_FIX;
            end
            S_FIX: begin
                q_d     = (sa_q ^ sb_q) ? WIDTH'(-dvd_q) : dvd_q;
                r_d     = sa_q ? WIDTH'(-rem_q) : rem_q;
                dz_d    = 1'b0;
                ov_d    = ovf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            bmag_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ovf_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ovf_q   <= ovf_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign Q        = q_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign DivZero  = dz_q;
    assign Overflow = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed sign/flag cases, busy and
// reset interplay, then random operands against a truncating-division model.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B, Q, R;
    logic         busy, done, DivZero, Overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .busy(busy), .done(done),
        .DivZero(DivZero), .Overflow(Overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic, C-style truncation toward zero.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q = '0; r = a; dz = 1'b1;
        end else if (sa == -(1 << (W - 1)) && sb == -1) begin
            q = a; r = '0; ov = 1'b1;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (busy) bc++;
        end
        if (!done) chk("timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [W-1:0] eq, er;
        logic edz, eov;
        int n, bc;
        model(a, b, eq, er, edz, eov);
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        wait_done(n, bc);
        chk({tag, ".lat"}, n, (b == '0) ? 1 : W + 2);
        chk({tag, ".busy"}, bc, (b == '0) ? 0 : W + 1);
        chk({tag, ".busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({tag, ".Q"}, {28'b0, Q}, {28'b0, eq});
        chk({tag, ".R"}, {28'b0, R}, {28'b0, er});
        chk({tag, ".dz"}, {31'b0, DivZero}, {31'b0, edz});
        chk({tag, ".ov"}, {31'b0, Overflow}, {31'b0, eov});
        @(negedge clk);
        chk({tag, ".done_1cyc"}, {31'b0, done}, 32'd0);
        chk({tag, ".Q_hold"}, {28'b0, Q}, {28'b0, eq});
        chk({tag, ".R_hold"}, {28'b0, R}, {28'b0, er});
    endtask

    initial begin
        int n, bc, cnt;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        chk("rst.Q", {28'b0, Q}, 32'd0);
        chk("rst.R", {28'b0, R}, 32'd0);
        chk("rst.flags", {28'b0, busy, done, DivZero, Overflow}, 32'd0);
        rst = 1'b0;

        run_op(4'b0111, 4'b0010, "p7d2");
        run_op(4'b1001, 4'b0010, "n7d2");
        run_op(4'b0111, 4'b1110, "p7dn2");
        run_op(4'b1001, 4'b1110, "n7dn2");
        run_op(4'b1000, 4'b1111, "ovf");
        run_op(4'b0101, 4'b0000, "div0");
        run_op(4'b1000, 4'b0001, "min_d1");
        run_op(4'b0011, 4'b0111, "small");

        // Start during busy is ignored
        @(negedge clk);
        start = 1'b1; A = 4'd6; B = 4'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; A = 4'd1; B = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        chk("busy_ign.Q", {28'b0, Q}, 32'd2);
        chk("busy_ign.R", {28'b0, R}, 32'd0);
        // Back-to-back start in the done cycle
        start = 1'b1; A = 4'd1; B = 4'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, bc);
        chk("b2b.lat", n, W + 2);
        chk("b2b.Q", {28'b0, Q}, 32'd1);
        chk("b2b.R", {28'b0, R}, 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; A = 4'd7; B = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst.busy", {31'b0, busy}, 32'd0);
        chk("arst.done", {31'b0, done}, 32'd0);
        chk("arst.Q", {28'b0, Q}, 32'd0);
        chk("arst.R", {28'b0, R}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("arst.no_done", cnt, 0);
        run_op(4'b0111, 4'b0010, "after_rst");

        repeat (40) run_op(W'($urandom), W'($urandom), "rnd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
